// File: rtl/adaptive_threshold_ask_detector.sv
// ASK slicer with self-derived thresholds: peak/floor envelope tracking, hysteresis band
// around the envelope midpoint, and a consecutive-sample glitch filter before committing rx.
module adaptive_threshold_ask_detector #(
   parameter int WIDTH       = 16,
   parameter int DECAY_SHIFT = 8,
   parameter int HYST_SHIFT  = 2,
   parameter int GLITCH_LEN  = 4,
   parameter int MIN_SPAN    = 256,
   parameter int CNT_WIDTH   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic             rx,
   output logic             rx_edge,
   output logic             locked,
   output logic [WIDTH-1:0] o_upthreshold,
   output logic [WIDTH-1:0] o_downthreshold
);

   // One extra bit keeps span and peak+floor exact even at full scale.
   localparam int EW = WIDTH + 1;
   localparam logic signed [EW-1:0] SMAX = EW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [EW-1:0] SMIN = EW'(-(2 ** (WIDTH - 1)));
   localparam logic [EW-1:0] MIN_SPAN_V = EW'(MIN_SPAN);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(GLITCH_LEN - 1);

   logic signed [EW-1:0] peak_q, peak_d, floor_q, floor_d;
   logic                 init_q, init_d;
   logic                 state_q, state_d;
   logic                 locked_q, locked_d;
   logic                 rx_edge_q, rx_edge_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     up_q, up_d, down_q, down_d;

   logic                 accept;
   logic                 cand;
   logic signed [EW-1:0] x_ext;
   logic signed [EW-1:0] span, mid, hyst, decay, up_cur, down_cur;
   logic signed [EW-1:0] span_n, mid_n, hyst_n, up_n, down_n;

   function automatic logic [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
      if (v > SMAX)      return SMAX[WIDTH-1:0];
      else if (v < SMIN) return SMIN[WIDTH-1:0];
      else               return v[WIDTH-1:0];
   endfunction

   assign accept = i_tvalid & enable;
   assign x_ext  = $signed({i_tdata[WIDTH-1], i_tdata});

   // Thresholds that judge the current sample come from the envelope before it moves.
   assign span     = peak_q - floor_q;
   assign mid      = (peak_q + floor_q) >>> 1;
   assign hyst     = span >>> HYST_SHIFT;
   assign decay    = span >>> DECAY_SHIFT;
   assign up_cur   = mid + hyst;
   assign down_cur = mid - hyst;

   // Reported thresholds and lock follow the post-update envelope (what the next sample sees).
   assign span_n = peak_d - floor_d;
   assign mid_n  = (peak_d + floor_d) >>> 1;
   assign hyst_n = span_n >>> HYST_SHIFT;
   assign up_n   = mid_n + hyst_n;
   assign down_n = mid_n - hyst_n;

   // State register
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         peak_q    <= '0;
         floor_q   <= '0;
         init_q    <= 1'b1;
         state_q   <= 1'b0;
         cnt_q     <= '0;
         locked_q  <= 1'b0;
         rx_edge_q <= 1'b0;
         up_q      <= '0;
         down_q    <= '0;
      end else begin
         peak_q    <= peak_d;
         floor_q   <= floor_d;
         init_q    <= init_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         locked_q  <= locked_d;
         rx_edge_q <= rx_edge_d;
         up_q      <= up_d;
         down_q    <= down_d;
      end
   end

   // Envelope next-state
   always_comb begin
      peak_d  = peak_q;
      floor_d = floor_q;
      init_d  = init_q;
      if (accept) begin
         if (init_q) begin
            peak_d  = x_ext;
            floor_d = x_ext;
            init_d  = 1'b0;
         end else begin
            peak_d  = (x_ext > peak_q)  ? x_ext : peak_q - decay;
            floor_d = (x_ext < floor_q) ? x_ext : floor_q + decay;
         end
      end
   end

   // Slicer decision, glitch filter and lock next-state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      locked_d  = locked_q;
      rx_edge_d = 1'b0;
      up_d      = up_q;
      down_d    = down_q;
      cand      = state_q;
      if (accept) begin
         if (locked_q) begin
            if (x_ext >= up_cur)        cand = 1'b1;
            else if (x_ext <= down_cur) cand = 1'b0;
            else                        cand = state_q;
            if (cand == state_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = cand;
               cnt_d     = '0;
               rx_edge_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end else begin
            // Losing lock forces idle; a forced 1->0 still reports an edge downstream.
            state_d   = 1'b0;
            cnt_d     = '0;
            rx_edge_d = state_q;
         end
         locked_d = ($unsigned(span_n) >= MIN_SPAN_V);
         up_d     = sat(up_n);
         down_d   = sat(down_n);
      end
   end

   // Outputs
   always_comb begin
      i_tready = enable;
      rx       = ~state_q;
   end

   assign rx_edge         = rx_edge_q;
   assign locked          = locked_q;
   assign o_upthreshold   = up_q;
   assign o_downthreshold = down_q;

endmodule

// File: tb/tb_adaptive_threshold_ask_detector.sv
// Directed + randomized bench for adaptive_threshold_ask_detector with a spec-level
// integer reference model feeding an expected-output queue.
module tb_adaptive_threshold_ask_detector;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset, clear, enable, i_tvalid;
   logic [W-1:0] i_tdata;
   logic         i_tready, rx, rx_edge, locked;
   logic [W-1:0] o_upthreshold, o_downthreshold;

   int tests_run = 0;
   int tests_failed = 0;

   logic [34:0] exp_q[$];

   int m_peak, m_floor, m_cnt, m_up, m_down;
   bit m_init, m_state, m_locked, m_edge;

   adaptive_threshold_ask_detector dut (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable),
      .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .rx(rx), .rx_edge(rx_edge), .locked(locked),
      .o_upthreshold(o_upthreshold), .o_downthreshold(o_downthreshold)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic int sat16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Reference model: one call per clock edge, pushes the expected post-edge outputs.
   task automatic model_step(input int x, input bit v, input bit en, input bit rs, input bit cl);
      int span, mid, hyst, up, dn, d, np, nf, nspan;
      bit cand;
      m_edge = 1'b0;
      if (rs || cl) begin
         m_peak = 0; m_floor = 0; m_init = 1'b1; m_state = 1'b0;
         m_cnt = 0; m_locked = 1'b0; m_up = 0; m_down = 0;
      end else if (v && en) begin
         span = m_peak - m_floor;
         mid  = (m_peak + m_floor) >>> 1;
         hyst = span >>> 2;
         up   = mid + hyst;
         dn   = mid - hyst;
         d    = span >>> 8;
         if (m_locked) begin
            if (x >= up)      cand = 1'b1;
            else if (x <= dn) cand = 1'b0;
            else              cand = m_state;
            if (cand == m_state) m_cnt = 0;
            else if (m_cnt == 3) begin
               m_state = cand; m_cnt = 0; m_edge = 1'b1;
            end else m_cnt = m_cnt + 1;
         end else begin
            m_edge = m_state; m_state = 1'b0; m_cnt = 0;
         end
         if (m_init) begin
            np = x; nf = x; m_init = 1'b0;
         end else begin
            np = (x > m_peak)  ? x : m_peak - d;
            nf = (x < m_floor) ? x : m_floor + d;
         end
         m_peak = np; m_floor = nf;
         nspan    = np - nf;
         m_locked = (nspan >= 256);
         mid      = (np + nf) >>> 1;
         hyst     = nspan >>> 2;
         m_up     = sat16(mid + hyst);
         m_down   = sat16(mid - hyst);
      end
      exp_q.push_back({~m_state, m_edge, m_locked, m_up[15:0], m_down[15:0]});
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Driver: apply one cycle of inputs, advance one edge, compare against the scoreboard.
   task automatic step(input int x, input bit v = 1'b1, input bit en = 1'b1,
                       input bit rs = 1'b0, input bit cl = 1'b0);
      logic [34:0] e;
      i_tdata  = W'(x);
      i_tvalid = v;
      enable   = en;
      reset    = rs;
      clear    = cl;
      #1;
      chk("tready", i_tready, en);
      model_step(x, v, en, rs, cl);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         chk("queue_underflow", 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk("rx", rx, e[34]);
         chk("rx_edge", rx_edge, e[33]);
         chk("locked", locked, e[32]);
         chk("up", $signed(o_upthreshold), $signed(e[31:16]));
         chk("down", $signed(o_downthreshold), $signed(e[15:0]));
      end
   endtask

   initial begin
      int edges, n;
      i_tdata = '0; i_tvalid = 1'b0; enable = 1'b0; reset = 1'b1; clear = 1'b0;
      @(negedge clk);

      // Reset state, then lock-up and first fall.
      step(0, 1, 1, 1, 0);
      chk("rst_rx", rx, 1);
      chk("rst_locked", locked, 0);
      step(0);
      step(1000);
      chk("t2_locked", locked, 1);
      chk("t2_up", $signed(o_upthreshold), 750);
      chk("t2_down", $signed(o_downthreshold), 250);
      for (int i = 0; i < 3; i++) begin
         step(1000);
         chk("t2_rx_hold", rx, 1);
      end
      step(1000);
      chk("t2_rx_fall", rx, 0);
      chk("t2_edge", rx_edge, 1);

      // Mid-stream reset with a partial glitch count pending.
      step(0); step(0);
      step(1000, 1, 1, 1, 0);
      chk("t1_rx", rx, 1);
      chk("t1_locked", locked, 0);
      chk("t1_up", $signed(o_upthreshold), 0);
      chk("t1_down", $signed(o_downthreshold), 0);
      step(0);
      for (int i = 0; i < 4; i++) step(1000);
      chk("t1_cnt_cleared", rx, 1);
      step(1000);
      chk("t1_commit", rx, 0);

      // Glitch rejection while high.
      edges = 0;
      for (int i = 0; i < 3; i++) begin step(0); edges += rx_edge; end
      step(1000); edges += rx_edge;
      for (int i = 0; i < 3; i++) begin step(0); edges += rx_edge; end
      chk("t3_rx", rx, 0);
      chk("t3_edges", edges, 0);

      // In-band holds in both states; enable/valid gating.
      for (int i = 0; i < 8; i++) step(500);
      chk("t4_band_hi", rx, 0);
      for (int i = 0; i < 4; i++) step(0);
      chk("t4_to_low", rx, 1);
      for (int i = 0; i < 8; i++) step(500);
      chk("t4_band_lo", rx, 1);
      for (int i = 0; i < 3; i++) step(1000, 1, 0);
      for (int i = 0; i < 3; i++) step(1000, 0, 1);
      chk("t4_gated_rx", rx, 1);
      chk("t4_gated_edge", rx_edge, 0);

      // Lock loss under constant input, starting from clear.
      step(0, 1, 1, 0, 1);
      step(0);
      for (int i = 0; i < 5; i++) step(1000);
      chk("t5_high", rx, 0);
      edges = 0;
      n = 0;
      while (n < 1000) begin
         step(0);
         edges += rx_edge;
         n++;
         if (!locked) break;
      end
      chk("t5_budget", (n < 1000), 1);
      chk("t5_unlocked", locked, 0);
      chk("t5_rx", rx, 1);
      chk("t5_edges", edges, 1);

      // Full-scale span.
      step(0, 1, 1, 1, 0);
      step(32767);
      step(-32768);
      chk("t6_locked", locked, 1);
      chk("t6_up", $signed(o_upthreshold), 16382);
      chk("t6_down", $signed(o_downthreshold), -16384);

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         step(int'($urandom_range(0, 65535)) - 32768,
              $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
              1'b0, $urandom_range(0, 60) == 0);
      end

      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
